mac_block_accumulator: RTL

Downstream stage of the multiply-accumulate datapath. Consumes the registered `A*B+C` result stream, sums a fixed-length block of `LEN` results, and presents the block total on a valid/ready output. It turns the per-cycle MAC stream into one sum per block for the next processing stage.

---
 rtl/sun_parameter.sv | 14 +
 rtl/mac_block_accumulator.sv | 107 ++++++++++
 2 files changed

// File: rtl/sun_parameter.sv
// Shared datapath parameters for the MAC pipeline.
// Holds the base width, the default block length and the block-accumulator states.
package sun_parameter;

  localparam int sun = 8;
  localparam int MAC_ACC_LEN = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } mac_acc_state_t;

endpackage

// File: rtl/mac_block_accumulator.sv
// Sums LEN MAC results per block and hands the total out on valid/ready.
// Define MAC_ACC_SAT_EN for a saturating accumulator with an overflow flag.
module mac_block_accumulator
  import sun_parameter::*;
#(
  parameter int W     = sun * 2,
  parameter int LEN   = MAC_ACC_LEN,
  parameter int ACC_W = W + 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_ovf
);

  localparam int CW = $clog2(LEN + 1);

  mac_acc_state_t   state;
  logic [ACC_W-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [ACC_W-1:0] nxt;
  logic             accept;
  logic             last;
  logic             leave;

  assign in_ready = (state != DONE);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (cnt == CW'(LEN - 1));
  assign leave    = (state == DONE) && out_ready;

`ifdef MAC_ACC_SAT_EN
  logic [ACC_W:0] wide;
  logic           carry;
  logic           ovf;

  always_comb begin
    wide  = {1'b0, acc} + {1'b0, ACC_W'(in_data)};
    carry = wide[ACC_W];
    nxt   = carry ? '1 : wide[ACC_W-1:0];
  end

  // Sticky carry for the running block; published with the total.
  always_ff @(posedge clk) begin
    if (!rst_n || clear || leave) begin
      ovf     <= 1'b0;
      out_ovf <= 1'b0;
    end else if (accept) begin
      ovf <= ovf | carry;
      if (last) out_ovf <= ovf | carry;
    end
  end
`else
  assign nxt     = acc + ACC_W'(in_data);
  assign out_ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ACC: begin
          if (accept) begin
            acc   <= nxt;
            cnt   <= cnt + 1'b1;
            state <= ACC;
            if (last) begin
              state     <= DONE;
              out_sum   <= nxt;
              out_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          cnt       <= '0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
